seg7_result_display: RTL and testbench
======================================

Name: seg7_result_display

Overview:
- Downstream consumer of the ALU result bus Y; shows its value in decimal on a 4-digit multiplexed seven-segment display.
- A sequential double-dabble converter turns the 8-bit result into sign, hundreds, tens and ones digits, latched for display.
- A scan counter time-multiplexes the latched digits onto shared segment and anode lines.
- The result is read as unsigned or as two's complement, selected by signed_mode.

Parameters:
- SCAN_COUNT, 50000: clock cycles each digit stays lit before the scan advances. Must be >= 2.

Ports:
- clock  input  1  system clock; every register is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- value_in  input  8  result bus from the ALU stage (its Y output).
- signed_mode  input  1  1 = value_in is two's complement (-128..127); 0 = unsigned (0..255).
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  output  4  digit anodes, active-low, one-hot when lit, registered. an[3] is leftmost, an[0] is rightmost.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (asynchronous, active-high):
  - seg=7'b1111111, an=4'b1111, busy=0.
  - FSM goes to IDLE; scan counter=0; digit_idx=0.
  - Display registers = {blank, blank, blank, 0}.
  - last_val=0, last_mode=0.
  - Reset during a conversion aborts it; no partial result is ever latched.
- FSM states:
  - IDLE: busy=0. On an edge where {value_in, signed_mode} != {last_val, last_mode}, capture src_val and src_mode, then go to ABS (edge e0).
  - ABS (e1): if src_mode and src_val[7], mag = (~src_val)+1 taken as an 8-bit unsigned value (8'h80 gives 128) and neg=1. Otherwise mag=src_val and neg=0. Clear the 12-bit BCD register and the bit counter. Go to SHIFT.
  - SHIFT (e2..e9): once per edge, add 3 to every BCD nibble >= 5, then shift {bcd, mag} left by 1. After the 8th shift, go to LATCH.
  - LATCH (e10): write the display registers, set last_val/last_mode = src, go to IDLE.
- busy = (state != IDLE). Display registers change only at LATCH, exactly 10 edges after the detecting edge.
- value_in changes while busy are ignored mid-flight. Any remaining mismatch is detected at the first IDLE edge after LATCH.
- Display register content:
  - Sign digit: minus if neg, else blank.
  - Hundreds: blank if 0.
  - Tens: blank if both hundreds and tens are 0.
  - Ones: always shown.
- Segment codes (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, minus=0111111, blank=1111111.
- Scan:
  - The counter runs 0..SCAN_COUNT-1 and wraps.
  - On wrap, digit_idx advances 0→1→2→3→0.
  - Every edge: an <= ~(4'b0001 << digit_idx) and seg <= code of digit[digit_idx].
  - So an/seg lag digit_idx by one edge and are never mismatched with each other.
  - Scanning continues unaffected during conversion.
- Simultaneous events: a mismatch detected in the same edge as LATCH is not seen until the following IDLE edge. Scan wrap and LATCH in the same edge: seg on the next edge uses the new display registers.

Test Plan (SCAN_COUNT=4):
1. Reset released with value_in=0, signed_mode=0 → busy stays 0. Over 16 cycles an cycles 1110, 1101, 1011, 0111. seg=1000000 when an=1110, otherwise 1111111.
2. value_in=8'hFF, signed_mode=0 → busy high for exactly 10 cycles after the detecting edge. Then an[2]/an[1]/an[0] show 0100100 / 0010010 / 0010010 ("255"), and an[3] is blank.
3. Hold 8'hFF, raise signed_mode → reconversion. an[3]=0111111, an[2] blank, an[1] blank, an[0]=1111001 ("-1").
4. signed_mode=1 with 8'h80 → "-128" (0111111, 1111001, 0100100, 0000000). Then 8'h7F → "127" with sign blank.
5. value_in=5, then 42 applied 3 edges after detection → "5" latched at e10. Busy falls, 42 is detected at e11, and "42" (an[1]=0011001, an[0]=0100100) is latched at e21.
6. Assert reset during SHIFT (e5) → seg=1111111, an=1111, busy=0 immediately. After release with value_in=0, ones shows 0 and no conversion occurs.

Source files
------------

// File: rtl/seg7_result_display.sv
// seg7_result_display: turns an 8-bit ALU result into sign/hundreds/tens/ones digits
// with a sequential double-dabble converter and scans them onto a 4-digit LED display.
module seg7_result_display #(
   parameter int unsigned SCAN_COUNT = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] value_in,
   input  logic       signed_mode,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       busy
);
   localparam int unsigned VAL_W  = 8;
   localparam int unsigned BCD_W  = 12;
   localparam int unsigned DIG_W  = 4;
   localparam int unsigned NDIG   = 4;
   localparam int unsigned BITC_W = 3;
   localparam int unsigned CNT_W  = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;

   localparam logic [DIG_W-1:0]  DIG_MINUS = DIG_W'(10);
   localparam logic [DIG_W-1:0]  DIG_BLANK = DIG_W'(11);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_COUNT - 1);
   localparam logic [BITC_W-1:0] BIT_LAST  = BITC_W'(VAL_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_ABS, S_SHIFT, S_LATCH} state_t;

   state_t                       state_q, state_d;
   logic [VAL_W-1:0]             src_val_q, src_val_d;
   logic                         src_mode_q, src_mode_d;
   logic [VAL_W-1:0]             mag_q, mag_d;
   logic                         neg_q, neg_d;
   logic [BCD_W-1:0]             bcd_q, bcd_d;
   logic [BITC_W-1:0]            bit_cnt_q, bit_cnt_d;
   logic [VAL_W-1:0]             last_val_q, last_val_d;
   logic                         last_mode_q, last_mode_d;
   logic [NDIG-1:0][DIG_W-1:0]   dig_q, dig_d;
   logic [CNT_W-1:0]             scan_cnt_q, scan_cnt_d;
   logic [1:0]                   digit_idx_q, digit_idx_d;
   logic [6:0]                   seg_q, seg_d;
   logic [3:0]                   an_q, an_d;
   logic                         busy_q, busy_d;
   logic [BCD_W-1:0]             bcd_adj;

   // Active-low {g,f,e,d,c,b,a} pattern for a stored digit code.
   function automatic logic [6:0] seg_code(input logic [DIG_W-1:0] d);
      case (d)
         4'd0:    seg_code = 7'b1000000;
         4'd1:    seg_code = 7'b1111001;
         4'd2:    seg_code = 7'b0100100;
         4'd3:    seg_code = 7'b0110000;
         4'd4:    seg_code = 7'b0011001;
         4'd5:    seg_code = 7'b0010010;
         4'd6:    seg_code = 7'b0000010;
         4'd7:    seg_code = 7'b1111000;
         4'd8:    seg_code = 7'b0000000;
         4'd9:    seg_code = 7'b0010000;
         4'd10:   seg_code = 7'b0111111;
         default: seg_code = 7'b1111111;
      endcase
   endfunction

   // Conversion FSM: detect change, take magnitude, double-dabble, latch digits.
   always_comb begin
      state_d     = state_q;
      src_val_d   = src_val_q;
      src_mode_d  = src_mode_q;
      mag_d       = mag_q;
      neg_d       = neg_q;
      bcd_d       = bcd_q;
      bit_cnt_d   = bit_cnt_q;
      last_val_d  = last_val_q;
      last_mode_d = last_mode_q;
      dig_d       = dig_q;
      bcd_adj     = bcd_q;

      case (state_q)
         S_IDLE: begin
            if ({value_in, signed_mode} != {last_val_q, last_mode_q}) begin
               src_val_d  = value_in;
               src_mode_d = signed_mode;
               state_d    = S_ABS;
            end
         end
         S_ABS: begin
            if (src_mode_q && src_val_q[VAL_W-1]) begin
               mag_d = (~src_val_q) + VAL_W'(1);
               neg_d = 1'b1;
            end else begin
               mag_d = src_val_q;
               neg_d = 1'b0;
            end
            bcd_d     = '0;
            bit_cnt_d = '0;
            state_d   = S_SHIFT;
         end
         S_SHIFT: begin
            for (int i = 0; i < 3; i++) begin
               if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
            {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
            bit_cnt_d      = bit_cnt_q + BITC_W'(1);
            if (bit_cnt_q == BIT_LAST) state_d = S_LATCH;
         end
         S_LATCH: begin
            dig_d[3] = neg_q ? DIG_MINUS : DIG_BLANK;
            dig_d[2] = (bcd_q[11:8] == 4'd0) ? DIG_BLANK : bcd_q[11:8];
            dig_d[1] = (bcd_q[11:4] == 8'd0) ? DIG_BLANK : bcd_q[7:4];
            dig_d[0] = bcd_q[3:0];
            last_val_d  = src_val_q;
            last_mode_d = src_mode_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Display scan: an/seg follow digit_idx one edge later, always as a matched pair.
   always_comb begin
      scan_cnt_d  = scan_cnt_q + CNT_W'(1);
      digit_idx_d = digit_idx_q;
      if (scan_cnt_q == CNT_LAST) begin
         scan_cnt_d  = '0;
         digit_idx_d = digit_idx_q + 2'd1;
      end
      an_d  = ~(4'b0001 << digit_idx_q);
      seg_d = seg_code(dig_q[digit_idx_q]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         src_val_q   <= '0;
         src_mode_q  <= 1'b0;
         mag_q       <= '0;
         neg_q       <= 1'b0;
         bcd_q       <= '0;
         bit_cnt_q   <= '0;
         last_val_q  <= '0;
         last_mode_q <= 1'b0;
         dig_q       <= {DIG_BLANK, DIG_BLANK, DIG_BLANK, DIG_W'(0)};
         scan_cnt_q  <= '0;
         digit_idx_q <= '0;
         seg_q       <= 7'b1111111;
         an_q        <= 4'b1111;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_val_q   <= src_val_d;
         src_mode_q  <= src_mode_d;
         mag_q       <= mag_d;
         neg_q       <= neg_d;
         bcd_q       <= bcd_d;
         bit_cnt_q   <= bit_cnt_d;
         last_val_q  <= last_val_d;
         last_mode_q <= last_mode_d;
         dig_q       <= dig_d;
         scan_cnt_q  <= scan_cnt_d;
         digit_idx_q <= digit_idx_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
         busy_q      <= busy_d;
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_seg7_result_display.sv
// Bench for seg7_result_display: directed display cases plus random values checked
// against a decimal-arithmetic model of what the four digits should show.
module tb_seg7_result_display;
   localparam int unsigned SC = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] value_in;
   logic       signed_mode;
   logic [6:0] seg;
   logic [3:0] an;
   logic       busy;

   int checks = 0;
   int errors = 0;
   logic [7:0] last_v = 8'd0;
   logic       last_m = 1'b0;

   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] MINUS = 7'b0111111;

   seg7_result_display #(.SCAN_COUNT(SC)) dut (
      .clock(clock), .reset(reset), .value_in(value_in), .signed_mode(signed_mode),
      .seg(seg), .an(an), .busy(busy)
   );

   always #5 clock = ~clock;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
         3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   // Expected {an3, an2, an1, an0} segment patterns for a value read in a given mode.
   function automatic logic [27:0] expect_disp(input logic [7:0] v, input logic m);
      int val, mag, h, t, o;
      logic [6:0] p3, p2, p1, p0;
      val = m ? int'($signed(v)) : int'(v);
      mag = (val < 0) ? -val : val;
      h = mag / 100;
      t = (mag / 10) % 10;
      o = mag % 10;
      p3 = (val < 0) ? MINUS : BLANK;
      p2 = (h == 0) ? BLANK : seg_of(h);
      p1 = (h == 0 && t == 0) ? BLANK : seg_of(t);
      p0 = seg_of(o);
      return {p3, p2, p1, p0};
   endfunction

   // Watch one full scan period and collect the pattern shown on each anode.
   task automatic observe(output logic [27:0] cap, output logic [3:0] seen, output int bad);
      cap = '1; seen = '0; bad = 0;
      for (int k = 0; k < 4 * SC; k++) begin
         @(posedge clock); #1;
         case (an)
            4'b1110: begin cap[6:0]   = seg; seen[0] = 1'b1; end
            4'b1101: begin cap[13:7]  = seg; seen[1] = 1'b1; end
            4'b1011: begin cap[20:14] = seg; seen[2] = 1'b1; end
            4'b0111: begin cap[27:21] = seg; seen[3] = 1'b1; end
            default: bad++;
         endcase
      end
   endtask

   // Apply a value, then count busy cycles until busy falls (bounded).
   task automatic run_conversion(input logic [7:0] v, input logic m, output int len);
      @(negedge clock);
      value_in = v; signed_mode = m; len = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clock); #1;
         if (busy) len++;
         else if (len > 0) break;
      end
      last_v = v; last_m = m;
   endtask

   task automatic test_reset;
      reset = 1'b1; value_in = 8'd0; signed_mode = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg: got %b want 1111111", seg); end
      checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_idle_scan;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      for (int k = 0; k < 4 * SC; k++) begin
         @(posedge clock); #1;
         exp_an  = ~(4'b0001 << (k / SC));
         exp_seg = (k / SC == 0) ? 7'b1000000 : BLANK;
         checks++; if (an !== exp_an) begin errors++; $display("FAIL idle_an[%0d]: got %b want %b", k, an, exp_an); end
         checks++; if (seg !== exp_seg) begin errors++; $display("FAIL idle_seg[%0d]: got %b want %b", k, seg, exp_seg); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy[%0d]: got %b want 0", k, busy); end
      end
   endtask

   task automatic test_unsigned_255;
      int len; logic [27:0] cap; logic [3:0] seen; int bad;
      logic [27:0] want;
      want = {BLANK, 7'b0100100, 7'b0010010, 7'b0010010};
      run_conversion(8'hFF, 1'b0, len);
      checks++; if (len !== 10) begin errors++; $display("FAIL busy_len_255: got %0d want 10", len); end
      observe(cap, seen, bad);
      checks++; if (cap !== want || seen !== 4'hF || bad != 0) begin errors++; $display("FAIL disp_255: got %h seen %b bad %0d want %h", cap, seen, bad, want); end
   endtask

   task automatic test_signed_directed;
      int len; logic [27:0] cap; logic [3:0] seen; int bad;
      logic [27:0] want;
      run_conversion(8'hFF, 1'b1, len);
      want = {MINUS, BLANK, BLANK, 7'b1111001};
      checks++; if (len !== 10) begin errors++; $display("FAIL busy_len_m1: got %0d want 10", len); end
      observe(cap, seen, bad);
      checks++; if (cap !== want || bad != 0) begin errors++; $display("FAIL disp_m1: got %h bad %0d want %h", cap, bad, want); end
      run_conversion(8'h80, 1'b1, len);
      want = {MINUS, 7'b1111001, 7'b0100100, 7'b0000000};
      observe(cap, seen, bad);
      checks++; if (cap !== want || bad != 0) begin errors++; $display("FAIL disp_m128: got %h bad %0d want %h", cap, bad, want); end
      run_conversion(8'h7F, 1'b1, len);
      want = {BLANK, 7'b1111001, 7'b0100100, 7'b1111000};
      observe(cap, seen, bad);
      checks++; if (cap !== want || bad != 0) begin errors++; $display("FAIL disp_127: got %h bad %0d want %h", cap, bad, want); end
   endtask

   task automatic test_back_to_back;
      logic [27:0] five, cap, want;
      logic [6:0] exp_seg;
      logic [3:0] seen; int bad;
      five = expect_disp(8'd5, 1'b0);
      @(negedge clock);
      value_in = 8'd5; signed_mode = 1'b0;
      @(posedge clock); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_e0: got %b want 1", busy); end
      for (int e = 1; e <= 21; e++) begin
         @(posedge clock); #1;
         if (e == 10) begin checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_e10: got %b want 0", busy); end end
         if (e == 11 || e == 20) begin checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_e%0d: got %b want 1", e, busy); end end
         if (e == 21) begin checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_e21: got %b want 0", busy); end end
         if (e >= 11) begin
            case (an)
               4'b1110: exp_seg = five[6:0];
               4'b1101: exp_seg = five[13:7];
               4'b1011: exp_seg = five[20:14];
               default: exp_seg = five[27:21];
            endcase
            checks++; if (seg !== exp_seg) begin errors++; $display("FAIL b2b_five_e%0d: got %b an %b want %b", e, seg, an, exp_seg); end
         end
         if (e == 3) begin @(negedge clock); value_in = 8'd42; end
      end
      last_v = 8'd42; last_m = 1'b0;
      want = {BLANK, BLANK, 7'b0011001, 7'b0100100};
      observe(cap, seen, bad);
      checks++; if (cap !== want || bad != 0) begin errors++; $display("FAIL b2b_disp_42: got %h bad %0d want %h", cap, bad, want); end
   endtask

   task automatic test_random;
      logic [7:0] v; logic m; logic differ;
      int len; logic [27:0] cap, want; logic [3:0] seen; int bad;
      for (int n = 0; n < 24; n++) begin
         v = 8'($urandom_range(0, 255));
         m = 1'($urandom_range(0, 1));
         differ = ({v, m} != {last_v, last_m});
         run_conversion(v, m, len);
         checks++;
         if (len != (differ ? 10 : 0)) begin errors++; $display("FAIL rand_busy[%0d] v=%h m=%b: got %0d want %0d", n, v, m, len, differ ? 10 : 0); end
         want = expect_disp(v, m);
         observe(cap, seen, bad);
         checks++; if (cap !== want || seen !== 4'hF || bad != 0) begin errors++; $display("FAIL rand_disp[%0d] v=%h m=%b: got %h bad %0d want %h", n, v, m, cap, bad, want); end
      end
   endtask

   task automatic test_reset_mid_shift;
      logic [7:0] v; logic [27:0] cap, want; logic [3:0] seen; int bad;
      v = (last_v == 8'd99 && !last_m) ? 8'd98 : 8'd99;
      @(negedge clock);
      value_in = v; signed_mode = 1'b0;
      repeat (6) @(posedge clock);
      #1 reset = 1'b1;
      #1;
      checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL midrst_seg: got %b want 1111111", seg); end
      checks++; if (an !== 4'b1111) begin errors++; $display("FAIL midrst_an: got %b want 1111", an); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      value_in = 8'd0; signed_mode = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      last_v = 8'd0; last_m = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clock); #1;
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_busy[%0d]: got %b want 0", k, busy); end
      end
      want = {BLANK, BLANK, BLANK, 7'b1000000};
      observe(cap, seen, bad);
      checks++; if (cap !== want || seen !== 4'hF || bad != 0) begin errors++; $display("FAIL midrst_disp: got %h bad %0d want %h", cap, bad, want); end
   endtask

   initial begin
      test_reset;
      test_idle_scan;
      test_unsigned_255;
      test_signed_directed;
      test_back_to_back;
      test_random;
      test_reset_mid_shift;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
